// File: rtl/voice_allocator.sv
// Polyphonic voice allocator. It takes note-on/note-off events over a
// valid/ready handshake and binds each note to one of NUM_VOICES voices.
// The order of preference is retrigger, then the lowest free voice, then the
// least-recently-allocated voice. Each event takes two cycles: the first
// latches the event and the second applies the decision.
module voice_allocator #(
  parameter int NUM_VOICES     = 4,
  parameter int NOTE_WIDTH     = 7,
  parameter int VELOCITY_WIDTH = 7
) (
  input  logic                                 clock_50_000_000,
  input  logic                                 reset,
  input  logic                                 event_valid,
  output logic                                 event_ready,
  input  logic                                 event_note_on,
  input  logic [NOTE_WIDTH-1:0]                event_note,
  input  logic [VELOCITY_WIDTH-1:0]            event_velocity,
  input  logic                                 panic,
  output logic [NUM_VOICES-1:0]                voice_active,
  output logic [NUM_VOICES*NOTE_WIDTH-1:0]     voice_note,
  output logic [NUM_VOICES*VELOCITY_WIDTH-1:0] voice_velocity,
  output logic [NUM_VOICES-1:0]                voice_clear,
  output logic [15:0]                          steal_count
);

  localparam int AW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [AW-1:0] OLDEST_AGE = AW'(NUM_VOICES - 1);

  typedef enum logic {
    ST_IDLE,
    ST_DECIDE
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Per-voice state
  logic [NUM_VOICES-1:0]     r_active;
  logic [NUM_VOICES-1:0]     r_clear;
  logic [NOTE_WIDTH-1:0]     r_note [NUM_VOICES];
  logic [VELOCITY_WIDTH-1:0] r_vel  [NUM_VOICES];
  logic [AW-1:0]             r_age  [NUM_VOICES];
  logic [15:0]               r_steal_count;

  // Event captured at accept
  logic                      r_ev_note_on;
  logic [NOTE_WIDTH-1:0]     r_ev_note;
  logic [VELOCITY_WIDTH-1:0] r_ev_vel;

  // Decision signals
  logic          w_accept;
  logic          w_hit_any;
  logic [AW-1:0] w_hit_idx;
  logic          w_free_any;
  logic [AW-1:0] w_free_idx;
  logic [AW-1:0] w_old_idx;
  logic [AW-1:0] w_target;
  logic          w_steal;
  logic [AW-1:0] w_age_next [NUM_VOICES];

  // State register
  always_ff @(posedge clock_50_000_000) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // Next state and handshake; panic forces IDLE and blocks acceptance
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_state_next = r_state;
    event_ready  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        event_ready = 1'b1;
        if (event_valid && !panic) w_state_next = ST_DECIDE;
      end
      ST_DECIDE: w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
    if (panic) w_state_next = ST_IDLE;
  end

  assign w_accept = event_valid && event_ready && !panic;

  // Voice search: scan from high to low so the lowest matching index wins
  always_comb begin
    // NOTE: combinational logic uses blocking '=' so each later loop iteration sees the
    // earlier ones; sequential state always uses non-blocking '<='.
    w_hit_any  = 1'b0;
    w_hit_idx  = '0;
    w_free_any = 1'b0;
    w_free_idx = '0;
    w_old_idx  = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (r_active[i] && (r_note[i] == r_ev_note)) begin
        w_hit_any = 1'b1;
        w_hit_idx = AW'(i);
      end
      if (!r_active[i]) begin
        w_free_any = 1'b1;
        w_free_idx = AW'(i);
      end
      if (r_age[i] == OLDEST_AGE) w_old_idx = AW'(i);
    end
    w_steal  = !w_hit_any && !w_free_any;
    w_target = w_hit_any ? w_hit_idx : (w_free_any ? w_free_idx : w_old_idx);
  end

  // LRU ages after touching the target: younger voices age by one, target becomes 0
  always_comb begin
    for (int i = 0; i < NUM_VOICES; i++) begin
      w_age_next[i] = r_age[i];
      if (AW'(i) == w_target)              w_age_next[i] = '0;
      else if (r_age[i] < r_age[w_target]) w_age_next[i] = r_age[i] + 1'b1;
    end
  end

  // Event latch, voice state, ages and steal counter
  always_ff @(posedge clock_50_000_000) begin
    if (reset) begin
      // NOTE: the per-voice arrays are reset explicitly because their contents drive outputs
      // that must be zero out of reset. A pure storage RAM would be left unreset.
      r_active      <= '0;
      r_clear       <= '0;
      r_steal_count <= '0;
      r_ev_note_on  <= 1'b0;
      r_ev_note     <= '0;
      r_ev_vel      <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        r_note[i] <= '0;
        r_vel[i]  <= '0;
        r_age[i]  <= AW'(i);
      end
    end else begin
      r_clear <= '0;
      if (panic) begin
        // Pending decision is dropped. Notes, velocities and ages are kept.
        r_active <= '0;
      end else if (r_state == ST_DECIDE) begin
        if (r_ev_note_on) begin
          r_note[w_target]   <= r_ev_note;
          r_vel[w_target]    <= r_ev_vel;
          r_active[w_target] <= 1'b1;
          r_clear[w_target]  <= 1'b1;
          r_age              <= w_age_next;
          if (w_steal && (r_steal_count != 16'hFFFF))
            r_steal_count <= r_steal_count + 16'd1;
        end else if (w_hit_any) begin
          r_active[w_hit_idx] <= 1'b0;
        end
      end
      if (w_accept) begin
        // A zero-velocity note-on is a note-off.
        r_ev_note_on <= event_note_on && (event_velocity != '0);
        r_ev_note    <= event_note;
        r_ev_vel     <= event_velocity;
      end
    end
  end

  // Flatten per-voice arrays onto the output buses
  always_comb begin
    voice_note     = '0;
    voice_velocity = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      voice_note[i*NOTE_WIDTH +: NOTE_WIDTH]             = r_note[i];
      voice_velocity[i*VELOCITY_WIDTH +: VELOCITY_WIDTH] = r_vel[i];
    end
  end

  assign voice_active = r_active;
  assign voice_clear  = r_clear;
  assign steal_count  = r_steal_count;

endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
- Polyphonic voice scheduler that sits between the MIDI event decoder and a bank of NUM_VOICES oscillator voices.
- Accepts note-on/note-off events over a valid/ready handshake and assigns each note to a voice: free voice first, otherwise steals the least-recently-allocated voice.
- Drives per-voice note, velocity, active and one-cycle clear (phase restart) outputs. The downstream period LUT and the oscillators consume these outputs.

Parameters:
- NUM_VOICES, 4, number of oscillator voices managed; power of two, at least 2.
- NOTE_WIDTH, 7, MIDI note number width.
- VELOCITY_WIDTH, 7, MIDI velocity width.

Ports:
- clock_50_000_000  input  1  system clock. One clock; reset is synchronous and active-high.
- reset  input  1  synchronous, active-high reset.
- event_valid  input  1  event present.
- event_ready  output  1  allocator can accept an event.
- event_note_on  input  1  1 = note-on, 0 = note-off.
- event_note  input  NOTE_WIDTH  note number.
- event_velocity  input  VELOCITY_WIDTH  note-on velocity; ignored for note-off.
- panic  input  1  all-notes-off request.
- voice_active  output  NUM_VOICES  voice i currently sounding.
- voice_note  output  NUM_VOICES*NOTE_WIDTH  note of voice i, in slice i.
- voice_velocity  output  NUM_VOICES*VELOCITY_WIDTH  velocity of voice i.
- voice_clear  output  NUM_VOICES  one-cycle pulse that restarts oscillator i.
- steal_count  output  16  saturating count of voice steals.

Behaviour:
- Reset values: voice_active=0, voice_note=0, voice_velocity=0, voice_clear=0, steal_count=0, event_ready=1, FSM=IDLE.
- Reset sets age[i]=i, so voice NUM_VOICES-1 is the oldest.
- FSM has two states, IDLE and DECIDE.
  - IDLE: event_ready=1. An event is accepted when event_valid && event_ready. Accepting latches note_on, note and velocity, then goes to DECIDE.
  - DECIDE: event_ready=0. Applies the decision at the end of the cycle, then returns to IDLE.
  - Timing: accept at edge k; outputs update at edge k+1; voice_clear is high during the cycle after edge k+1; event_ready is high again after edge k+1.
  - Throughput is one event per 2 cycles.
- Note-on with velocity 0 is treated as a note-off.
- Note-on decision uses the first matching rule:
  - (a) An active voice already holds the note (retrigger): that voice keeps the note, takes the new velocity, gets a clear pulse, and is touched.
  - (b) A free voice exists: the lowest-index inactive voice gets the note and velocity, becomes active, gets a clear pulse, and is touched.
  - (c) No voice is free (steal): the voice with age==NUM_VOICES-1 is reassigned with a clear pulse and touched. steal_count increments and saturates at 0xFFFF.
- Note-off decision:
  - The active voice holding the note gets voice_active=0. voice_note and voice_velocity are retained and no clear pulse is issued.
  - A note-off with no match changes nothing.
- Touch(v) maintains ages as an LRU permutation: every voice with age < age[v] increments, and age[v] becomes 0.
  - Ages always form a permutation of 0..NUM_VOICES-1.
  - Ages are unchanged by note-off and by panic.
- panic has priority over everything except reset. In the same edge it clears all voice_active bits, discards any pending DECIDE event (no clear pulse, no steal count) and forces IDLE.
  - An event presented while panic is high is not accepted.
- At most one voice_clear bit is high in any cycle.
- event_note and event_velocity are sampled only at accept; changes during DECIDE are ignored.
- Reset during DECIDE aborts the event; all outputs take their reset values on that edge.

Test Plan:
- Reset, then note-on 60 vel 100 → after 2 edges voice_active=0001, voice_note[0]=60, voice_clear=0001 for exactly 1 cycle, event_ready high again.
- Note-on 60, 62, 64, 67 back-to-back with valid held → voices 0-3 get 60/62/64/67; event_ready toggles 1,0; voice_active=1111.
- With all four voices active (oldest is voice 0, note 60), note-on 69 → voice 0 gets note 69, voice_clear=0001, steal_count=1; voices 1-3 unchanged.
- Voices holding 60/62, then note-on 62 vel 20 → voice 1 velocity becomes 20 with a clear pulse; no new voice is used; steal_count unchanged.
- Note-off 62, then note-on 72 vel 0, then note-off 50 (unheld) → voice 1 deactivates with note 62 retained; the other two events cause no change and no clear pulse.
- Accept a note-on, then assert panic in the DECIDE cycle → voice_active=0, no voice_clear, FSM back in IDLE; the next note-on lands in voice 0.
